// File: rtl/beat_sequencer.sv
// Purpose: plays a programmed list of {tempo, beats} steps into beat_generator's S select.
// Latency: start sampled in IDLE -> LOAD next edge -> S_out valid one edge later.
// Backpressure: none; pulse is counted only after the post-change guard window, stop wins over all.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  pattern write port, {tempo[6:4], beats[3:0]}, beats==0 means 16
//   last_step, loop        final step index; wrap to step 0 after it (1) or finish (0)
//   start, stop            begin playback (IDLE only) / abort from any state
//   pulse                  beat pulse from beat_generator
//   S_out, step, beat_cnt  tempo select, active step index, beats counted in step
//   busy, done             high in LOAD/RUN / one-cycle strobe on non-loop completion
module beat_sequencer #(
    parameter int DEPTH = 8,
    parameter int GUARD = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_data,
    input  logic [AW-1:0] last_step,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    input  logic          pulse,
    output logic [2:0]    S_out,
    output logic [AW-1:0] step,
    output logic [3:0]    beat_cnt,
    output logic          busy,
    output logic          done
);

    localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [6:0]    mem [DEPTH];
    logic [3:0]    cur_beats, beats_nxt;
    logic [GW-1:0] guard, guard_nxt;
    logic [AW-1:0] step_nxt;
    logic [2:0]    s_nxt;
    logic [3:0]    cnt_nxt;
    logic          busy_nxt, done_nxt;
    logic [4:0]    cnt_inc, beats_eff;
    logic          counted;

    // Pattern memory: writes land in any state; the active step only sees
    // them at its next LOAD because tempo and beats are latched there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign cnt_inc   = {1'b0, beat_cnt} + 5'd1;
    assign beats_eff = (cur_beats == 4'd0) ? 5'd16 : {1'b0, cur_beats};
    assign counted   = pulse && (guard == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step      <= '0;
            S_out     <= '0;
            beat_cnt  <= '0;
            cur_beats <= '0;
            guard     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            S_out     <= s_nxt;
            beat_cnt  <= cnt_nxt;
            cur_beats <= beats_nxt;
            guard     <= guard_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        s_nxt     = S_out;
        cnt_nxt   = beat_cnt;
        beats_nxt = cur_beats;
        guard_nxt = (guard != '0) ? guard - GW'(1) : guard;
        done_nxt  = 1'b0;

        if (stop) begin
            state_nxt = IDLE;
            step_nxt  = '0;
            s_nxt     = '0;
            cnt_nxt   = '0;
            guard_nxt = GW'(GUARD);
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = LOAD;
                        step_nxt  = '0;
                    end
                end
                LOAD: begin
                    // S_out is rewritten on every LOAD, even with an unchanged
                    // tempo, so the guard always masks the generator's restart pulse.
                    s_nxt     = mem[step][6:4];
                    beats_nxt = mem[step][3:0];
                    cnt_nxt   = '0;
                    guard_nxt = GW'(GUARD);
                    state_nxt = RUN;
                end
                RUN: begin
                    if (counted) begin
                        if (cnt_inc < beats_eff) begin
                            cnt_nxt = cnt_inc[3:0];
                        end else if (step != last_step) begin
                            // Natural AW-bit wrap handles step > last_step.
                            step_nxt  = step + AW'(1);
                            state_nxt = LOAD;
                        end else if (loop) begin
                            step_nxt  = '0;
                            state_nxt = LOAD;
                        end else begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                            s_nxt     = '0;
                            guard_nxt = GW'(GUARD);
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt == LOAD) || (state_nxt == RUN);
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// Purpose: directed checks of beat_sequencer playback, guard, loop, stop and reset.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; all waits are fixed cycle counts.
module tb_beat_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_data;
    logic [AW-1:0] last_step;
    logic          loop;
    logic          start;
    logic          stop;
    logic          pulse;
    logic [2:0]    S_out;
    logic [AW-1:0] step;
    logic [3:0]    beat_cnt;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    beat_sequencer #(.DEPTH(DEPTH), .GUARD(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .last_step (last_step),
        .loop      (loop),
        .start     (start),
        .stop      (stop),
        .pulse     (pulse),
        .S_out     (S_out),
        .step      (step),
        .beat_cnt  (beat_cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int addr, input logic [6:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    // start edge -> LOAD; next edge -> RUN with S_out loaded
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("busy_after_start", int'(busy), 1);
        tick();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic beat();
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        last_step = '0; loop = 1'b0; start = 1'b0; stop = 1'b0; pulse = 1'b0;
        #12;
        check_val("rst_S_out", int'(S_out), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_step", int'(step), 0);
        reset = 1'b1;
        tick();

        // Two-step play, with the guard window probed on step 0
        write_mem(0, {3'd7, 4'd2});
        write_mem(1, {3'd2, 4'd3});
        last_step = 3'd1; loop = 1'b0;
        do_start();
        check_val("t2_S0", int'(S_out), 7);
        check_val("t2_cnt0", int'(beat_cnt), 0);
        pulse = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("guard_masked", int'(beat_cnt), 0);
        end
        tick();
        pulse = 1'b0;
        check_val("guard_4th", int'(beat_cnt), 1);
        beat();
        check_val("t2_step1", int'(step), 1);
        check_val("t2_S_hold", int'(S_out), 7);
        tick();
        check_val("t2_S1", int'(S_out), 2);
        check_val("t2_cnt_clr", int'(beat_cnt), 0);
        idle_ticks(3);
        beat();
        beat();
        check_val("t2_cnt2", int'(beat_cnt), 2);
        check_val("t2_done_early", int'(done), 0);
        beat();
        check_val("t2_done", int'(done), 1);
        check_val("t2_S_zero", int'(S_out), 0);
        check_val("t2_busy_off", int'(busy), 0);
        tick();
        check_val("t2_done_once", int'(done), 0);
        check_val("t2_idle_busy", int'(busy), 0);

        // Loop through all eight steps with one beat each
        for (int i = 0; i < DEPTH; i++) write_mem(i, {3'(i), 4'd1});
        last_step = 3'd7; loop = 1'b1;
        do_start();
        check_val("t4_S_step0", int'(S_out), 0);
        for (int k = 0; k < DEPTH; k++) begin
            idle_ticks(3);
            beat();
            check_val("t4_step", int'(step), (k + 1) % DEPTH);
            check_val("t4_busy", int'(busy), 1);
            check_val("t4_no_done", int'(done), 0);
            tick();
            check_val("t4_S", int'(S_out), (k + 1) % DEPTH);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_val("t4_stop_busy", int'(busy), 0);
        check_val("t4_stop_step", int'(step), 0);

        // beats==0 counts as 16
        write_mem(0, {3'd5, 4'd0});
        last_step = 3'd0; loop = 1'b0;
        do_start();
        check_val("t5_S", int'(S_out), 5);
        idle_ticks(3);
        for (int i = 0; i < 15; i++) beat();
        check_val("t5_cnt15", int'(beat_cnt), 15);
        check_val("t5_not_done", int'(done), 0);
        beat();
        check_val("t5_done", int'(done), 1);
        tick();

        // Stop and start together in RUN, then restart with new contents
        write_mem(0, {3'd6, 4'd5});
        do_start();
        idle_ticks(3);
        beat();
        check_val("t6_cnt1", int'(beat_cnt), 1);
        write_mem(0, {3'd3, 4'd2});
        check_val("t6_S_unchanged", int'(S_out), 6);
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        check_val("t6_busy", int'(busy), 0);
        check_val("t6_S", int'(S_out), 0);
        check_val("t6_cnt", int'(beat_cnt), 0);
        check_val("t6_done", int'(done), 0);
        tick();
        check_val("t6_still_idle", int'(busy), 0);
        do_start();
        check_val("t6_new_S", int'(S_out), 3);
        idle_ticks(3);
        beat();
        beat();
        check_val("t6_new_done", int'(done), 1);
        tick();

        // Asynchronous reset mid-RUN
        do_start();
        idle_ticks(3);
        beat();
        check_val("t1_pre_cnt", int'(beat_cnt), 1);
        #2 reset = 1'b0;
        #1;
        check_val("t1_async_S", int'(S_out), 0);
        check_val("t1_async_cnt", int'(beat_cnt), 0);
        check_val("t1_async_busy", int'(busy), 0);
        #1 reset = 1'b1;
        tick();
        check_val("t1_idle_busy", int'(busy), 0);
        check_val("t1_idle_step", int'(step), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
